// File: rtl/bus_pkg.sv
// Shared types and widths for the 8088 minimum-mode bus initiator.
package bus_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned AHI_W  = ADDR_W - 8;

    // One-hot bus cycle phases
    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } bus_state_t;

    // Captured host request
    typedef struct packed {
        logic              write;
        logic              io;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter: counts TW states and flags when MAX_WAIT has been reached.
module bus_wait_timer #(
    parameter int unsigned MAX_WAIT  = 15,
    parameter int unsigned WAIT_BITS = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [WAIT_BITS-1:0] count;

    // Counter plus registered "count == MAX_WAIT" flag; inc is never issued once expired
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (inc) begin
            count   <= count + WAIT_BITS'(1);
            expired <= (count == WAIT_BITS'(MAX_WAIT - 1));
        end
    end

endmodule

// File: rtl/i8088_bus_master.sv
// 8088 minimum-mode bus initiator: runs single-byte T1-T4 cycles with READY wait states.
module i8088_bus_master
    import bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 15,
    parameter int unsigned WAIT_BITS = $clog2(MAX_WAIT + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req,
    input  logic              req_write,
    input  logic              req_io,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              accept,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              ALE,
    output logic              RD,
    output logic              WR,
    output logic              IOM,
    output logic              DTR,
    output logic              DEN,
    output logic [AHI_W-1:0]  A,
    inout  wire  [DATA_W-1:0] AD,
    input  logic              READY
);

    bus_state_t        state;
    bus_state_t        state_nxt;
    bus_req_t          cur_q;
    bus_req_t          cur_nxt;
    logic              tmr_clear;
    logic              tmr_inc;
    logic              wait_expired;
    logic              timeout_c;
    logic              rd_ok_c;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_q;

    // Host handshake: a new request can be taken when idle or finishing T4
    assign accept = req && ((state == IDLE) || (state == T4));

    bus_wait_timer #(
        .MAX_WAIT  (MAX_WAIT),
        .WAIT_BITS (WAIT_BITS)
    ) u_wait (
        .clk     (CLK),
        .reset   (RESET),
        .clear   (tmr_clear),
        .inc     (tmr_inc),
        .expired (wait_expired)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state, request capture and wait-timer control
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_q;
        tmr_clear = 1'b0;
        tmr_inc   = 1'b0;
        timeout_c = 1'b0;
        rd_ok_c   = 1'b0;
        case (state)
            IDLE, T4: begin
                if (req) begin
                    cur_nxt.write = req_write;
                    cur_nxt.io    = req_io;
                    cur_nxt.addr  = req_addr;
                    cur_nxt.wdata = req_wdata;
                    state_nxt     = T1;
                    tmr_clear     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            T1: state_nxt = T2;
            T2: state_nxt = T3;
            T3, TW: begin
                if (READY) begin
                    state_nxt = T4;
                    rd_ok_c   = !cur_q.write;
                end else if (!wait_expired) begin
                    state_nxt = TW;
                    tmr_inc   = 1'b1;
                end else begin
                    state_nxt = T4;
                    timeout_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered bus pins and host status, decoded from the upcoming phase
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cur_q <= '0;
            ALE   <= 1'b0;
            RD    <= 1'b1;
            WR    <= 1'b1;
            DEN   <= 1'b1;
            IOM   <= 1'b0;
            DTR   <= 1'b0;
            A     <= '0;
            ad_oe <= 1'b0;
            ad_q  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            rdata <= '0;
        end else begin
            cur_q <= cur_nxt;
            ALE   <= (state_nxt == T1);
            RD    <= !((state_nxt inside {T2, T3, TW}) && !cur_nxt.write);
            WR    <= !((state_nxt inside {T2, T3, TW}) && cur_nxt.write);
            DEN   <= !(state_nxt inside {T2, T3, TW, T4});
            IOM   <= (state_nxt != IDLE) && cur_nxt.io;
            DTR   <= (state_nxt != IDLE) && cur_nxt.write;
            if (state_nxt != IDLE) A <= cur_nxt.addr[ADDR_W-1:8];
            ad_oe <= (state_nxt == T1) || (cur_nxt.write && (state_nxt inside {T2, T3, TW, T4}));
            ad_q  <= (state_nxt == T1) ? cur_nxt.addr[7:0] : cur_nxt.wdata;
            done  <= (state_nxt == T4);
            err   <= timeout_c;
            busy  <= (state_nxt != IDLE);
            if (rd_ok_c) rdata <= AD;
        end
    end

    // Multiplexed address/data pad
    assign AD = ad_oe ? ad_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_i8088_bus_master.sv
// Directed bench for i8088_bus_master with a cycle-level expectation model.
module tb_i8088_bus_master;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        ready;
    wire         accept, busy, done, err;
    wire  [7:0]  rdata;
    wire         ale, rd, wr, iom, dtr, den;
    wire  [11:0] a;
    tri   [7:0]  ad;
    logic        resp_oe;
    logic [7:0]  resp_d;

    assign ad = resp_oe ? resp_d : 8'bz;

    always #5 clk = ~clk;

    i8088_bus_master #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK(clk), .RESET(reset), .req(req), .req_write(req_write), .req_io(req_io),
        .req_addr(req_addr), .req_wdata(req_wdata), .accept(accept), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .ALE(ale), .RD(rd), .WR(wr),
        .IOM(iom), .DTR(dtr), .DEN(den), .A(a), .AD(ad), .READY(ready)
    );

    typedef struct {
        bit          write;
        bit          io;
        logic [19:0] addr;
        logic [7:0]  wdata;
        int          nlow;
        logic [7:0]  rsp;
        int          rst_at;
    } txn_t;

    typedef struct {
        logic        accept, busy, done, err, ale, rd, wr, iom, dtr, den;
        logic [11:0] a;
        logic [7:0]  ad;
        bit          ad_chk;
        logic [7:0]  rdata;
    } exp_t;

    exp_t        ex;
    bit          ex_valid = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cyc;
    int          start_cyc;
    logic [11:0] a_m;
    logic [7:0]  rdata_m;
    logic [11:0] t1_a;
    logic [7:0]  t1_ad;
    logic        last_err;
    txn_t        seq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, expv);
        end
    endtask

    function automatic txn_t mk(bit w, bit io, logic [19:0] ad_i, logic [7:0] wd,
                                int nlow, logic [7:0] rsp, int rst_at);
        txn_t t;
        t.write = w; t.io = io; t.addr = ad_i; t.wdata = wd;
        t.nlow = nlow; t.rsp = rsp; t.rst_at = rst_at;
        return t;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: DUT outputs against the model on every checked cycle
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cyc = cyc;
            last_err = err;
        end
        if (ale === 1'b1) begin
            t1_a  = a;
            t1_ad = ad;
        end
        if (ex_valid) begin
            chk("accept", 32'(accept), 32'(ex.accept));
            chk("busy",   32'(busy),   32'(ex.busy));
            chk("done",   32'(done),   32'(ex.done));
            chk("err",    32'(err),    32'(ex.err));
            chk("ALE",    32'(ale),    32'(ex.ale));
            chk("RD",     32'(rd),     32'(ex.rd));
            chk("WR",     32'(wr),     32'(ex.wr));
            chk("IOM",    32'(iom),    32'(ex.iom));
            chk("DTR",    32'(dtr),    32'(ex.dtr));
            chk("DEN",    32'(den),    32'(ex.den));
            chk("A",      {20'h0, a},  {20'h0, ex.a});
            chk("rdata",  {24'h0, rdata}, {24'h0, ex.rdata});
            if (ex.ad_chk) chk("AD", {24'h0, ad}, {24'h0, ex.ad});
        end
    end

    function automatic exp_t idle_exp(bit req_now);
        exp_t e;
        e.accept = req_now; e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0; e.ale = 1'b0;
        e.rd = 1'b1; e.wr = 1'b1; e.iom = 1'b0; e.dtr = 1'b0; e.den = 1'b1;
        e.a = a_m; e.ad = 8'bz; e.ad_chk = 1'b1; e.rdata = rdata_m;
        return e;
    endfunction

    task automatic present(input txn_t t);
        req       = 1'b1;
        req_write = t.write;
        req_io    = t.io;
        req_addr  = t.addr;
        req_wdata = t.wdata;
    endtask

    // Run the queued transactions back-to-back, then one idle cycle
    task automatic run_seq();
        done_cyc = -1;
        present(seq[0]);
        ready = 1'b1; resp_oe = 1'b0;
        ex = idle_exp(1'b1);
        @(posedge clk); #1;
        start_cyc = cyc - 1;
        for (int i = 0; i < seq.size(); i++) begin
            txn_t t;
            bit   tmo;
            int   w, len;
            t   = seq[i];
            tmo = (t.nlow > MAX_WAIT);
            w   = tmo ? MAX_WAIT : t.nlow;
            len = 4 + w;
            for (int c = 1; c <= len; c++) begin
                bit last, nextreq, strobe;
                last    = (c == len);
                nextreq = last && (i + 1 < seq.size());
                strobe  = (c >= 2) && (c < len);
                if (nextreq) present(seq[i+1]);
                else req = 1'b0;
                ready   = (c >= 3 && c < len && (tmo || (c - 3) < t.nlow)) ? 1'b0 : 1'b1;
                resp_oe = !t.write && strobe;
                resp_d  = t.rsp;
                if (c == 1) a_m = t.addr[19:8];
                if (last && !t.write && !tmo) rdata_m = t.rsp;
                ex.accept = nextreq;
                ex.busy   = 1'b1;
                ex.done   = last;
                ex.err    = last && tmo;
                ex.ale    = (c == 1);
                ex.rd     = !(strobe && !t.write);
                ex.wr     = !(strobe && t.write);
                ex.iom    = t.io;
                ex.dtr    = t.write;
                ex.den    = (c == 1);
                ex.a      = a_m;
                ex.rdata  = rdata_m;
                ex.ad_chk = 1'b1;
                if (c == 1)       ex.ad = t.addr[7:0];
                else if (t.write) ex.ad = t.wdata;
                else begin
                    ex.ad     = 8'bz;
                    ex.ad_chk = last;
                end
                @(negedge clk);
                if (c == t.rst_at) begin
                    reset = 1'b1;
                    @(posedge clk); #1;
                    reset = 1'b0; req = 1'b0; resp_oe = 1'b0; ready = 1'b1;
                    a_m = 12'h000; rdata_m = 8'h00;
                    ex = idle_exp(1'b0);
                    @(posedge clk); #1;
                    seq.delete();
                    return;
                end
                @(posedge clk); #1;
            end
        end
        req = 1'b0; resp_oe = 1'b0; ready = 1'b1;
        ex = idle_exp(1'b0);
        @(posedge clk); #1;
        seq.delete();
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_addr = '0; req_wdata = '0; ready = 1'b1; resp_oe = 1'b0; resp_d = '0;
        a_m = 12'h000; rdata_m = 8'h00; last_err = 1'b0;
        @(posedge clk); #1;
        ex = idle_exp(1'b0);
        ex_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Memory read, no waits
        seq.push_back(mk(1'b0, 1'b0, 20'h12345, 8'h00, 0, 8'hA5, 0));
        run_seq();
        chk("rd0_latency", 32'(done_cyc - start_cyc), 32'd4);
        chk("rd0_t1_a",  {20'h0, t1_a},  32'h123);
        chk("rd0_t1_ad", {24'h0, t1_ad}, 32'h45);
        chk("rd0_rdata", {24'h0, rdata}, 32'hA5);

        // I/O write, no waits
        seq.push_back(mk(1'b1, 1'b1, 20'h00080, 8'h3C, 0, 8'h00, 0));
        run_seq();
        chk("iow_latency", 32'(done_cyc - start_cyc), 32'd4);
        chk("iow_t1_ad", {24'h0, t1_ad}, 32'h80);
        chk("iow_rdata_kept", {24'h0, rdata}, 32'hA5);

        // Read with three wait states
        seq.push_back(mk(1'b0, 1'b0, 20'h0ABCD, 8'h00, 3, 8'h5A, 0));
        run_seq();
        chk("rd3_latency", 32'(done_cyc - start_cyc), 32'd7);
        chk("rd3_rdata", {24'h0, rdata}, 32'h5A);

        // READY stuck low: timeout after MAX_WAIT wait states
        seq.push_back(mk(1'b0, 1'b0, 20'h54321, 8'h00, 99, 8'hEE, 0));
        run_seq();
        chk("tmo_latency", 32'(done_cyc - start_cyc), 32'd19);
        chk("tmo_err", 32'(last_err), 32'd1);
        chk("tmo_rdata_kept", {24'h0, rdata}, 32'h5A);

        // Back-to-back write then read with req held
        seq.push_back(mk(1'b1, 1'b0, 20'h11111, 8'h77, 0, 8'h00, 0));
        seq.push_back(mk(1'b0, 1'b1, 20'h22222, 8'h00, 0, 8'hC3, 0));
        run_seq();
        chk("b2b_latency", 32'(done_cyc - start_cyc), 32'd8);
        chk("b2b_rdata", {24'h0, rdata}, 32'hC3);
        chk("b2b_a_hold", {20'h0, a}, 32'h222);

        // Reset during T3 of a write, then a normal read
        seq.push_back(mk(1'b1, 1'b0, 20'h33333, 8'h99, 0, 8'h00, 3));
        run_seq();
        chk("rst_no_done", 32'(done_cyc), 32'hFFFFFFFF);
        chk("rst_a", {20'h0, a}, 32'h000);
        seq.push_back(mk(1'b0, 1'b0, 20'h44444, 8'h00, 1, 8'h6E, 0));
        run_seq();
        chk("post_rst_latency", 32'(done_cyc - start_cyc), 32'd5);
        chk("post_rst_rdata", {24'h0, rdata}, 32'h6E);

        ex_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
